muldiv_seq: RTL and testbench

Multicycle signed multiply/divide sequencer that owns the Hi and Lo registers of the datapath. It is started by the main control FSM with a one-cycle start pulse, iterates over several cycles, then returns a one-cycle done pulse. hi_out and lo_out feed the write-data mux for MFHI/MFLO. The control FSM stalls in a wait state while busy is high.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_seq_if.sv | 41 ++++
 rtl/muldiv_div_step.sv | 26 ++
 rtl/muldiv_seq.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Purpose : shared types and constants for the multicycle multiply/divide sequencer.
// Latency : n/a (declarations only).
// Backpres: n/a.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Purpose : request/result bundle between the control FSM and muldiv_seq.
// Latency : n/a (wires only).
// Backpres: start is only honoured while busy is low; there is no queuing.
// Signals : start/op/a_in/b_in (request), busy/done/div_zero (status), hi_out/lo_out (Hi/Lo).
//           op_unsigned exists only when MULDIV_UNSIGNED_EN is defined.
interface muldiv_seq_if #(
    parameter int WIDTH = muldiv_pkg::MULDIV_WIDTH
);
    logic             start;
    logic             op;
`ifdef MULDIV_UNSIGNED_EN
    logic             op_unsigned;
`endif
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    // Control FSM side.
    modport master (
        output start, output op, output a_in, output b_in,
        input  busy,  input  done, input  div_zero,
        input  hi_out, input lo_out
`ifdef MULDIV_UNSIGNED_EN
        , output op_unsigned
`endif
    );

    // Sequencer side.
    modport slave (
        input  start, input  op, input  a_in, input  b_in,
        output busy,  output done, output div_zero,
        output hi_out, output lo_out
`ifdef MULDIV_UNSIGNED_EN
        , input op_unsigned
`endif
    );
endinterface

// File: rtl/muldiv_div_step.sv
// Purpose : one combinational restoring-division step on unsigned magnitudes.
// Latency : combinational, 0 cycles.
// Backpres: none; pure function of its inputs.
// Ports   : rem_i partial remainder, bit_i next dividend bit, div_i divisor,
//           rem_o next partial remainder, q_o quotient bit.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        // Extra top bit acts as the borrow: clear means shifted >= divisor.
        diff    = {1'b0, shifted} - {2'b00, div_i};
        q_o     = ~diff[WIDTH+1];
        // Remainder is always below the divisor, so WIDTH bits suffice.
        rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/muldiv_seq.sv
// Purpose : multicycle signed multiply (radix-2 Booth) / divide (restoring) owning Hi and Lo.
// Latency : MULT WIDTH+1 edges, DIV WIDTH+2 edges, DIV by zero 1 edge, start edge to done.
// Backpres: busy is high outside IDLE; start is ignored while busy, no queuing.
// Ports   : clk, reset (synchronous, active-high), bus (muldiv_seq_if.slave).
// Option  : MULDIV_UNSIGNED_EN adds bus.op_unsigned for MULTU/DIVU semantics.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_seq_if.slave   bus
);
    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]    acc_q, acc_d;      // Booth accumulator / division remainder
    logic [WIDTH-1:0]  q_q, q_d;          // multiplier / dividend shifting into quotient
    logic              qm1_q, qm1_d;      // Booth q[-1]
    logic [WIDTH:0]    m_q, m_d;          // multiplicand (sign-extended) / divisor magnitude
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              uns_q, uns_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              dz_q, dz_d;

    logic              start_uns;
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_abs, b_abs;
    logic [WIDTH:0]    booth_sum;
    logic              booth_fill;
    logic [WIDTH:0]    booth_acc;
    logic [WIDTH-1:0]  booth_q;
    logic [WIDTH-1:0]  div_rem;
    logic              div_qbit;

`ifdef MULDIV_UNSIGNED_EN
    assign start_uns = bus.op_unsigned;
`else
    assign start_uns = 1'b0;
`endif

    muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i (acc_q[WIDTH-1:0]),
        .bit_i (q_q[WIDTH-1]),
        .div_i (m_q[WIDTH-1:0]),
        .rem_o (div_rem),
        .q_o   (div_qbit)
    );

    // Operand conditioning for a start request.
    always_comb begin
        a_neg = ~start_uns & bus.a_in[WIDTH-1];
        b_neg = ~start_uns & bus.b_in[WIDTH-1];
        a_abs = a_neg ? (WIDTH'(0) - bus.a_in) : bus.a_in;
        b_abs = b_neg ? (WIDTH'(0) - bus.b_in) : bus.b_in;
    end

    // One multiply step. The accumulator carries one guard bit so that
    // subtracting the most negative multiplicand cannot overflow.
    always_comb begin
        booth_sum = acc_q;
        if (uns_q) begin
            // Unsigned: plain shift-and-add on zero-extended operands.
            if (q_q[0]) begin
                booth_sum = acc_q + m_q;
            end
        end else begin
            unique case ({q_q[0], qm1_q})
                2'b01:   booth_sum = acc_q + m_q;
                2'b10:   booth_sum = acc_q - m_q;
                default: booth_sum = acc_q;
            endcase
        end
        booth_fill = uns_q ? 1'b0 : booth_sum[WIDTH];
        booth_acc  = {booth_fill, booth_sum[WIDTH:1]};
        booth_q    = {booth_sum[0], q_q[WIDTH-1:1]};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        uns_d     = uns_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d = '0;
                    uns_d = start_uns;
                    if (bus.op == OP_MULT) begin
                        acc_d   = '0;
                        q_d     = bus.b_in;
                        qm1_d   = 1'b0;
                        m_d     = {(~start_uns & bus.a_in[WIDTH-1]), bus.a_in};
                        state_d = MULT;
                    end else if (bus.b_in == '0) begin
                        // Divide by zero: report immediately, Hi/Lo untouched.
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        acc_d     = '0;
                        q_d       = a_abs;
                        m_d       = {1'b0, b_abs};
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        state_d   = DIV;
                    end
                end
            end
            MULT: begin
                acc_d = booth_acc;
                q_d   = booth_q;
                qm1_d = q_q[0];
                if (cnt_q == CNT_LAST) begin
                    hi_d    = booth_acc[WIDTH-1:0];
                    lo_d    = booth_q;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DIV: begin
                acc_d = {1'b0, div_rem};
                q_d   = {q_q[WIDTH-2:0], div_qbit};
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIX: begin
                // Negating 0x80..0 yields 0x80..0, which is the wanted overflow result.
                lo_d    = neg_quo_q ? (WIDTH'(0) - q_q) : q_q;
                hi_d    = neg_rem_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            uns_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            uns_q     <= uns_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.div_zero = dz_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Purpose : self-checking bench for muldiv_seq with an expected-result scoreboard.
// Latency : checks WIDTH+1 / WIDTH+2 / 1 edge start-to-done latencies.
// Backpres: exercises start while busy (mid-operation and in DONE) and reset abort.
module tb_muldiv_seq;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    logic clk;
    logic reset;

    muldiv_seq_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t         sb_q[$];
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference behaviour built from SystemVerilog signed arithmetic.
    function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t                 e;
        logic signed [63:0]   p;
        logic signed [W-1:0]  sa, sb;
        sa = a;
        sb = b;
        e.dz = 1'b0;
        if (op == 1'b0) begin
            p     = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.lat = W + 1;
        end else if (b == '0) begin
            e.hi  = model_hi;
            e.lo  = model_lo;
            e.dz  = 1'b1;
            e.lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.hi  = '0;
            e.lo  = 32'h8000_0000;
            e.lat = W + 2;
        end else begin
            e.lo  = sa / sb;
            e.hi  = sa % sb;
            e.lat = W + 2;
        end
        return e;
    endfunction

    // Called just after an edge (#1); drives one request and follows it to done.
    task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit hold_in_done);
        exp_t         e;
        exp_t         got_e;
        int           edges;
        int           busy_cnt;
        bit           stable_ok;
        logic [W-1:0] hi0, lo0;

        e = model(op, a, b);
        sb_q.push_back(e);
        model_hi = e.hi;
        model_lo = e.lo;

        hi0 = bus.hi_out;
        lo0 = bus.lo_out;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        edges     = 1;
        bus.start = 1'b0;
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
        busy_cnt  = 0;
        stable_ok = 1'b1;

        while (!bus.done && edges < 200) begin
            if (bus.busy) busy_cnt++;
            if (bus.hi_out !== hi0 || bus.lo_out !== lo0) stable_ok = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end

        got_e = sb_q.pop_front();
        if (!bus.done) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            if (bus.busy) busy_cnt++;
            check({tag, "_latency"}, 64'(edges), 64'(got_e.lat));
            check({tag, "_hi"}, 64'(bus.hi_out), 64'(got_e.hi));
            check({tag, "_lo"}, 64'(bus.lo_out), 64'(got_e.lo));
            check({tag, "_div_zero"}, 64'(bus.div_zero), 64'(got_e.dz));
            check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(got_e.lat));
            check({tag, "_hilo_stable"}, 64'(stable_ok), 64'd1);
        end

        if (hold_in_done) begin
            // A divide-by-zero request here would re-enter DONE if accepted.
            bus.start = 1'b1;
            bus.op    = 1'b1;
            bus.b_in  = '0;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
        check({tag, "_dz_pulse"}, 64'(bus.div_zero), 64'd0);
    endtask

    initial begin
        int  edges;
        bit  seen_done;
        bit  seen_dz;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
`ifdef MULDIV_UNSIGNED_EN
        bus.op_unsigned = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dz", 64'(bus.div_zero), 64'd0);
        check("rst_hi", 64'(bus.hi_out), 64'd0);
        check("rst_lo", 64'(bus.lo_out), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_prep", 1'b1, 32'h0000_0451, 32'h0000_0020, 1'b0);
        run_op("div_by_zero", 1'b1, 32'd5, 32'd0, 1'b1);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_neg_div", 1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("rnd%0d", i), 1'(i % 2), $urandom, $urandom, 1'(i % 3 == 0));
        end

        // Abort: MULT started, extra start at edge 5, reset sampled at edge 10.
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a_in  = 32'd3;
        bus.b_in  = 32'd5;
        @(posedge clk);
        #1;
        edges     = 1;
        seen_done = 1'b0;
        seen_dz   = 1'b0;
        while (edges < 10) begin
            bus.start = (edges == 4);
            reset     = (edges == 9);
            if (edges == 4) begin
                bus.op   = 1'b1;
                bus.b_in = '0;
            end
            @(posedge clk);
            #1;
            edges++;
            if (bus.done) seen_done = 1'b1;
            if (bus.div_zero) seen_dz = 1'b1;
            if (edges == 5) check("abort_busy_e5", 64'(bus.busy), 64'd1);
        end
        bus.start = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hi", 64'(bus.hi_out), 64'd0);
        check("abort_lo", 64'(bus.lo_out), 64'd0);
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_no_dz", 64'(seen_dz), 64'd0);
        reset    = 1'b0;
        model_hi = '0;
        model_lo = '0;

        run_op("post_abort_mul", 1'b0, 32'hFFFF_FFFB, 32'd6, 1'b0);
        run_op("post_abort_div", 1'b1, 32'd1000, 32'd7, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
